// File: rtl/mmio_bus_arbiter_pkg.sv
// Shared types and constants for the MMIO interconnect: FSM states, error
// response data, the default slave memory map and the timeout counter sizing.
package mmio_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  localparam logic [31:0] MEM_BASE    = 32'h0000_0000;
  localparam logic [31:0] MEM_MASK    = 32'hF000_0000;
  localparam logic [31:0] SCREEN_BASE = 32'h2000_0000;
  localparam logic [31:0] SCREEN_MASK = 32'hFFFF_0000;
  localparam logic [31:0] BUTTON_BASE = 32'h3000_0000;
  localparam logic [31:0] BUTTON_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] UART_BASE   = 32'h4000_0000;
  localparam logic [31:0] UART_MASK   = 32'hFFFF_FF00;

  // Slave i sits at bits [i*32 +: 32], so memory is slave 0 and wins overlaps.
  localparam logic [127:0] DEF_SLAVE_BASE = {UART_BASE, BUTTON_BASE, SCREEN_BASE, MEM_BASE};
  localparam logic [127:0] DEF_SLAVE_MASK = {UART_MASK, BUTTON_MASK, SCREEN_MASK, MEM_MASK};

  function automatic int tmo_width(input int timeout_cyc);
    return $clog2(timeout_cyc + 1);
  endfunction

endpackage

// File: rtl/mmio_bus_arbiter_if.sv
// Core-side and slave-side bus bundles of the MMIO interconnect.
// Core side: cpu_ren/cpu_wen are level requests held until cpu_ready; cpu_ready is
// a one-cycle strobe and cpu_rdata/cpu_err are valid with it. Slave side: a one-hot
// s_ren/s_wen is held every cycle until the selected slave pulses s_ack for one cycle.
interface mmio_cpu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   cpu_addr;
    logic                cpu_ren;
    logic                cpu_wen;
    logic [DATA_W-1:0]   cpu_wdata;
    logic [DATA_W/8-1:0] cpu_wstrb;
    logic [DATA_W-1:0]   cpu_rdata;
    logic                cpu_ready;
    logic                cpu_err;

    modport master (
        output cpu_addr, cpu_ren, cpu_wen, cpu_wdata, cpu_wstrb,
        input  cpu_rdata, cpu_ready, cpu_err
    );
    modport slave (
        input  cpu_addr, cpu_ren, cpu_wen, cpu_wdata, cpu_wstrb,
        output cpu_rdata, cpu_ready, cpu_err
    );
endinterface

interface mmio_slv_if #(
    parameter int N_SLAVES = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
);
    logic [N_SLAVES-1:0]        s_ren;
    logic [N_SLAVES-1:0]        s_wen;
    logic [ADDR_W-1:0]          s_addr;
    logic [DATA_W-1:0]          s_wdata;
    logic [DATA_W/8-1:0]        s_wstrb;
    logic [N_SLAVES*DATA_W-1:0] s_rdata;
    logic [N_SLAVES-1:0]        s_ack;

    modport master (
        output s_ren, s_wen, s_addr, s_wdata, s_wstrb,
        input  s_rdata, s_ack
    );
    modport slave (
        input  s_ren, s_wen, s_addr, s_wdata, s_wstrb,
        output s_rdata, s_ack
    );
endinterface

// File: rtl/mmio_bus_arbiter_addr_decode.sv
// Combinational address decoder: first (lowest-index) base/mask window that
// matches the address selects the slave.
module mmio_addr_decode #(
    parameter int                         N_SLAVES = 4,
    parameter int                         ADDR_W   = 32,
    parameter int                         IDX_W    = 2,
    parameter logic [N_SLAVES*ADDR_W-1:0] BASE     = '0,
    parameter logic [N_SLAVES*ADDR_W-1:0] MASK     = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    // Scanning downward lets the lowest matching index overwrite the others.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((addr & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// MMIO interconnect: registers a core request, selects one slave, waits for its
// ack (or times out) and returns a one-cycle response with optional error.
module mmio_bus_arbiter
    import mmio_bus_pkg::*;
#(
    parameter int                         N_SLAVES    = 4,
    parameter int                         ADDR_W      = 32,
    parameter int                         DATA_W      = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE  = DEF_SLAVE_BASE,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK  = DEF_SLAVE_MASK,
    parameter int                         TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    mmio_cpu_if.slave         cpu,
    mmio_slv_if.master        slv,
    output logic [ADDR_W-1:0] err_addr,
    output logic [7:0]        err_cnt,
    output state_t            dbg_state
);

    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int TMO_W = tmo_width(TIMEOUT_CYC);

    state_t              state, next_state;
    logic                op_wr;
    logic [IDX_W-1:0]    idx_q;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                err_q;
    logic                dec_hit;
    logic [IDX_W-1:0]    dec_idx;
    logic                req;
    logic                sel_ack;
    logic                tmo_hit;
    logic                err_evt;
    logic [ADDR_W-1:0]   err_evt_addr;
    logic [N_SLAVES-1:0] sel_onehot;

    mmio_addr_decode #(
        .N_SLAVES (N_SLAVES),
        .ADDR_W   (ADDR_W),
        .IDX_W    (IDX_W),
        .BASE     (SLAVE_BASE),
        .MASK     (SLAVE_MASK)
    ) u_decode (
        .addr (cpu.cpu_addr),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    assign req     = cpu.cpu_ren | cpu.cpu_wen;
    assign sel_ack = slv.s_ack[idx_q];
    // tmo_cnt counts completed ACCESS cycles, so this flags the last allowed one.
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    assign err_evt = ((state == IDLE) && req && !dec_hit) ||
                     ((state == ACCESS) && !sel_ack && tmo_hit);
    assign err_evt_addr = (state == IDLE) ? cpu.cpu_addr : slv.s_addr;
    assign dbg_state    = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = dec_hit ? ACCESS : RESP;
            ACCESS:  if (sel_ack || tmo_hit) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Selects are decoded straight from the state register so reset drops them at once.
    always_comb begin
        sel_onehot        = '0;
        sel_onehot[idx_q] = 1'b1;
        slv.s_ren         = '0;
        slv.s_wen         = '0;
        if (state == ACCESS) begin
            if (op_wr) slv.s_wen = sel_onehot;
            else       slv.s_ren = sel_onehot;
        end
        cpu.cpu_ready = (state == RESP);
        cpu.cpu_err   = (state == RESP) && err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slv.s_addr    <= '0;
            slv.s_wdata   <= '0;
            slv.s_wstrb   <= '0;
            op_wr         <= 1'b0;
            idx_q         <= '0;
            tmo_cnt       <= '0;
            err_q         <= 1'b0;
            cpu.cpu_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        slv.s_addr  <= cpu.cpu_addr;
                        slv.s_wdata <= cpu.cpu_wdata;
                        slv.s_wstrb <= cpu.cpu_wstrb;
                        op_wr       <= cpu.cpu_wen;
                        idx_q       <= dec_idx;
                        tmo_cnt     <= '0;
                        if (!dec_hit) begin
                            err_q         <= 1'b1;
                            cpu.cpu_rdata <= DATA_W'(ERR_RDATA);
                        end
                    end
                end
                ACCESS: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (sel_ack) begin
                        err_q         <= 1'b0;
                        cpu.cpu_rdata <= op_wr ? '0 : slv.s_rdata[idx_q*DATA_W +: DATA_W];
                    end else if (tmo_hit) begin
                        err_q         <= 1'b1;
                        cpu.cpu_rdata <= DATA_W'(ERR_RDATA);
                    end
                end
                default: tmo_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_addr <= '0;
            err_cnt  <= '0;
        end else if (err_evt) begin
            err_addr <= err_evt_addr;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Randomized self-checking bench for mmio_bus_arbiter against a transaction-level
// model of decode, latency, response data and error bookkeeping.
module tb_mmio_bus_arbiter;
    import mmio_bus_pkg::*;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;
    localparam int NEVER = 99;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] err_addr;
    logic [7:0]    err_cnt;
    state_t        dbg_state;

    mmio_cpu_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_bus ();
    mmio_slv_if #(.N_SLAVES(N), .ADDR_W(AW), .DATA_W(DW)) slv_bus ();

    mmio_bus_arbiter #(.TIMEOUT_CYC(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu       (cpu_bus),
        .slv       (slv_bus),
        .err_addr  (err_addr),
        .err_cnt   (err_cnt),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] exp_q[$];
    logic [31:0]   m_base[N] = '{32'h0000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000};
    logic [31:0]   m_mask[N] = '{32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_FFFC, 32'hFFFF_FF00};
    logic [AW-1:0] m_err_addr = '0;
    int            m_err_cnt  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < N; i++)
            if ((a & m_mask[i]) == m_base[i]) return i;
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic bus_idle();
        cpu_bus.cpu_addr  = '0;
        cpu_bus.cpu_ren   = 1'b0;
        cpu_bus.cpu_wen   = 1'b0;
        cpu_bus.cpu_wdata = '0;
        cpu_bus.cpu_wstrb = '0;
        slv_bus.s_ack     = '0;
        slv_bus.s_rdata   = '0;
    endtask

    // One core transaction. ack_wait = wait cycles before the selected slave acks
    // (NEVER = no ack); stray adds an ack on a non-selected slave every cycle.
    task automatic run_txn(input logic [31:0] addr, input logic ren, input logic wen,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           input int ack_wait, input bit stray);
        logic [DW-1:0]    rd[N];
        logic [N*DW-1:0]  rpack;
        logic [N-1:0]     exp_sel, obs_sel, ack, stray_bit;
        logic [DW-1:0]    exp_data;
        int               idx, exp_lat, exp_sel_cnt, lat, sel_cnt;
        bit               exp_err, done;

        for (int i = 0; i < N; i++) begin
            rd[i] = $urandom;
            rpack[i*DW +: DW] = rd[i];
        end
        slv_bus.s_rdata = rpack;
        slv_bus.s_ack   = '0;

        idx       = ref_decode(addr);
        exp_sel   = '0;
        stray_bit = '0;
        if (idx >= 0) begin
            exp_sel[idx] = 1'b1;
            stray_bit[(idx + 1) % N] = 1'b1;
        end
        if (idx < 0) begin
            exp_lat = 1; exp_sel_cnt = 0; exp_err = 1'b1; exp_data = ERR_RDATA;
        end else if (ack_wait < TMO) begin
            exp_lat = ack_wait + 2; exp_sel_cnt = ack_wait + 1; exp_err = 1'b0;
            exp_data = wen ? '0 : rd[idx];
        end else begin
            exp_lat = TMO + 1; exp_sel_cnt = TMO; exp_err = 1'b1; exp_data = ERR_RDATA;
        end
        if (exp_err) begin
            m_err_addr = addr;
            if (m_err_cnt < 255) m_err_cnt++;
        end
        exp_q.push_back(exp_data);

        cpu_bus.cpu_addr  = addr;
        cpu_bus.cpu_ren   = ren;
        cpu_bus.cpu_wen   = wen;
        cpu_bus.cpu_wdata = wdata;
        cpu_bus.cpu_wstrb = wstrb;

        lat = 0; sel_cnt = 0; done = 1'b0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (cpu_bus.cpu_ready) begin
                done = 1'b1;
            end else begin
                check("sel", {slv_bus.s_ren, slv_bus.s_wen}, wen ? {4'b0, exp_sel} : {exp_sel, 4'b0});
                check("s_addr", slv_bus.s_addr, addr);
                if (wen) begin
                    check("s_wdata", slv_bus.s_wdata, wdata);
                    check("s_wstrb", slv_bus.s_wstrb, wstrb);
                end
                obs_sel = wen ? slv_bus.s_wen : slv_bus.s_ren;
                if (obs_sel != '0) sel_cnt++;
                cpu_bus.cpu_addr  = $urandom;
                cpu_bus.cpu_wdata = $urandom;
                cpu_bus.cpu_wstrb = 4'($urandom);
                ack = (sel_cnt - 1 == ack_wait) ? obs_sel : '0;
                if (stray) ack = ack | (stray_bit & ~obs_sel);
                slv_bus.s_ack = ack;
            end
        end

        slv_bus.s_ack   = '0;
        cpu_bus.cpu_ren = 1'b0;
        cpu_bus.cpu_wen = 1'b0;
        if (!done) begin
            check("ready_bound", 64'd0, 64'd1);
            void'(exp_q.pop_front());
        end else begin
            check("latency", lat, exp_lat);
            check("sel_cycles", sel_cnt, exp_sel_cnt);
            check("cpu_err", cpu_bus.cpu_err, exp_err);
            check("cpu_rdata", cpu_bus.cpu_rdata, exp_q.pop_front());
            check("sel_at_ready", {slv_bus.s_ren, slv_bus.s_wen}, 8'h00);
            check("err_addr", err_addr, m_err_addr);
            check("err_cnt", err_cnt, m_err_cnt);
        end
        @(negedge clk);
        check("ready_one_cycle", cpu_bus.cpu_ready, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        int          cls, op;

        bus_idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", cpu_bus.cpu_ready, 1'b0);
        check("rst_err", cpu_bus.cpu_err, 1'b0);
        check("rst_rdata", cpu_bus.cpu_rdata, 32'h0);
        check("rst_sel", {slv_bus.s_ren, slv_bus.s_wen}, 8'h00);
        check("rst_s_addr", slv_bus.s_addr, 32'h0);
        check("rst_err_addr", err_addr, 32'h0);
        check("rst_err_cnt", err_cnt, 8'h0);
        check("rst_state", dbg_state, IDLE);
        rst = 1'b0;
        @(negedge clk);

        // directed cases
        run_txn(32'h0000_0100, 1'b1, 1'b0, 32'h0, 4'h0, 0, 1'b0);
        run_txn(32'h2000_0010, 1'b0, 1'b1, 32'h0000_00A5, 4'b0001, 3, 1'b0);
        run_txn(32'h5000_0000, 1'b1, 1'b0, 32'h0, 4'h0, 0, 1'b0);
        run_txn(32'h3000_0000, 1'b1, 1'b0, 32'h0, 4'h0, NEVER, 1'b0);
        run_txn(32'h4000_0004, 1'b0, 1'b1, 32'hCAFE_F00D, 4'hF, 2, 1'b1);
        run_txn(32'h0000_0200, 1'b1, 1'b0, 32'h0, 4'h0, TMO - 1, 1'b0);
        run_txn(32'h2000_0000, 1'b1, 1'b1, 32'h1111_2222, 4'hC, 1, 1'b0);

        // randomized traffic
        for (int k = 0; k < 150; k++) begin
            cls = $urandom_range(0, 4);
            case (cls)
                0:       a = {4'h0, 28'($urandom)};
                1:       a = 32'h2000_0000 | 32'($urandom_range(0, 16'hFFFF));
                2:       a = 32'h3000_0000 | 32'($urandom_range(0, 3));
                3:       a = 32'h4000_0000 | 32'($urandom_range(0, 255));
                default: a = {4'($urandom_range(1, 15)), 28'($urandom)};
            endcase
            op = $urandom_range(0, 2);
            run_txn(a, op != 1, op != 0, $urandom, 4'($urandom),
                    $urandom_range(0, TMO + 1), bit'($urandom_range(0, 1)));
        end

        // error counter saturation
        for (int k = 0; k < 260; k++)
            run_txn({4'h6, 28'($urandom)}, 1'b1, 1'b0, 32'h0, 4'h0, 0, 1'b0);
        check("err_cnt_sat", err_cnt, 8'hFF);

        // reset in the middle of a slave access
        cpu_bus.cpu_addr = 32'h2000_0010;
        cpu_bus.cpu_wen  = 1'b1;
        cpu_bus.cpu_ren  = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_wen", slv_bus.s_wen, 4'b0010);
        rst = 1'b1;
        #1;
        check("rst_mid_wen", slv_bus.s_wen, 4'b0000);
        check("rst_mid_state", dbg_state, IDLE);
        cpu_bus.cpu_wen = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rst_mid_ready", cpu_bus.cpu_ready, 1'b0);
        end
        check("rst_mid_err_cnt", err_cnt, 8'h0);
        rst        = 1'b0;
        m_err_cnt  = 0;
        m_err_addr = '0;
        @(negedge clk);
        check("post_rst_ready", cpu_bus.cpu_ready, 1'b0);
        run_txn(32'h0000_0100, 1'b1, 1'b0, 32'h0, 4'h0, 0, 1'b0);

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
